// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder, one full-adder cell reused LSB first
//
// Purpose : adds two WIDTH-bit operands plus a carry-in over WIDTH clock cycles
//           using a single 1-bit full-adder cell, with a start/busy/done handshake.
// Ports   : i_clk    - system clock, rising edge
//           i_rst_n  - asynchronous active-low reset
//           i_start  - begin one addition (honoured in IDLE only)
//           i_a/i_b  - operands, sampled on the accepting edge
//           i_cin    - initial carry-in, sampled on the accepting edge
//           i_sub    - (SERIAL_ADDER_SUB_EN only) 1 = compute a - b
//           o_busy   - high while bits are being processed
//           o_done   - one-cycle pulse, o_sum/o_cout valid
//           o_sum    - registered result, held until the next accepted start
//           o_cout   - registered final carry (with i_sub: 1 = no borrow)
// Options : define SERIAL_ADDER_SUB_EN to add the i_sub port and subtract mode.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    // Partial result: only bits 0..WIDTH-2 are ever parked here; the final
    // bit comes straight from the adder cell on the last RUN edge.
    logic [WIDTH-1:1] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_done;

    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic             w_axb;
    logic             w_s;
    logic             w_c;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: a + ~b + 1.
    assign w_b_load = i_sub ? ~i_b : i_b;
    assign w_c_load = i_sub ? 1'b1 : i_cin;
`else
    assign w_b_load = i_b;
    assign w_c_load = i_cin;
`endif

    // The single full-adder cell.
    assign w_axb = r_a[0] ^ r_b[0];
    assign w_s   = w_axb ^ r_carry;
    assign w_c   = (r_a[0] & r_b[0]) | (w_axb & r_carry);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_carry <= w_c;
                    r_res[WIDTH-1] <= w_s;
                    for (int i = 1; i < WIDTH - 1; i++) begin
                        r_res[i] <= r_res[i+1];
                    end
                    if (r_cnt == LAST_BIT) begin
                        // Publish the whole result at once so partial sums
                        // never appear on the outputs.
                        r_sum   <= {w_s, r_res};
                        r_cout  <= w_c;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy = (r_state == S_RUN);
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl (WIDTH=8)
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in  = '0;
    logic [W-1:0] b_in  = '0;
    logic         cin   = 1'b0;
    logic         sub   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_a     (a_in),
        .i_b     (b_in),
        .i_cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .i_sub   (sub),
`endif
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout)
    );

    // Reference: plain modulo arithmetic, carry in bit W.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        logic [W-1:0] nb;
        nb = ~b;
        if (s) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Drives one operation and observes it; lat = negedges after the
    // accepting edge at which done was seen (-1 if never).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, input bit noise,
                         output int lat, output int busy_n, output bit sum_moved,
                         output logic [W-1:0] rs, output logic rc);
        logic [W-1:0] sum0;
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; cin = c; sub = s;
        @(negedge clk);
        start = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        lat = -1; busy_n = 0; sum_moved = 1'b0; sum0 = sum;
        for (int k = 0; k < 4 * W; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_n++;
            if (sum !== sum0) sum_moved = 1'b1;
            @(negedge clk);
            if (noise) begin
                start = (k <= W - 4);
                a_in = W'($urandom); b_in = W'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
            end
        end
        start = 1'b0;
        rs = sum; rc = cout;
    endtask

    task automatic test_reset;
        int lat, bn; bit mv; logic [W-1:0] rs; logic rc;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
        total_cnt++; if (sum !== '0) $display("FAIL reset_sum got %h exp 00", sum); else pass_cnt++;
        total_cnt++; if (cout !== 1'b0) $display("FAIL reset_cout got %b exp 0", cout); else pass_cnt++;
        #5 rst_n = 1'b1;
        do_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, lat, bn, mv, rs, rc);
        total_cnt++; if (lat !== W) $display("FAIL first_start_latency got %0d exp %0d", lat, W); else pass_cnt++;
        total_cnt++; if ({rc, rs} !== 9'h007) $display("FAIL first_start_result got %h exp 007", {rc, rs}); else pass_cnt++;
    endtask

    task automatic test_directed;
        int lat, bn; bit mv; logic [W-1:0] rs; logic rc;
        do_op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0, lat, bn, mv, rs, rc);
        total_cnt++; if (lat !== W) $display("FAIL dir_latency got %0d exp %0d", lat, W); else pass_cnt++;
        total_cnt++; if (bn !== W) $display("FAIL dir_busy_cycles got %0d exp %0d", bn, W); else pass_cnt++;
        total_cnt++; if (mv !== 1'b0) $display("FAIL dir_sum_stable_in_run got %b exp 0", mv); else pass_cnt++;
        total_cnt++; if ({rc, rs} !== 9'h08D) $display("FAIL dir_5a_33 got %h exp 08d", {rc, rs}); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0) $display("FAIL dir_done_one_cycle got %b exp 0", done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL dir_busy_after got %b exp 0", busy); else pass_cnt++;
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, lat, bn, mv, rs, rc);
        total_cnt++; if ({rc, rs} !== 9'h100) $display("FAIL dir_ff_01 got %h exp 100", {rc, rs}); else pass_cnt++;
        do_op(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, lat, bn, mv, rs, rc);
        total_cnt++; if ({rc, rs} !== 9'h100) $display("FAIL dir_ff_00_cin got %h exp 100", {rc, rs}); else pass_cnt++;
    endtask

    task automatic test_abort;
        int lat, bn, done_seen; bit mv; logic [W-1:0] rs; logic rc;
        do_op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0, lat, bn, mv, rs, rc);
        @(negedge clk);
        start = 1'b1; a_in = 8'h77; b_in = 8'h11; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL abort_busy_before got %b exp 1", busy); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if ({cout, sum} !== 9'h000) $display("FAIL abort_result got %h exp 000", {cout, sum}); else pass_cnt++;
        done_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        total_cnt++; if (done_seen !== 0) $display("FAIL abort_no_done got %0d exp 0", done_seen); else pass_cnt++;
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, lat, bn, mv, rs, rc);
        total_cnt++; if ({rc, rs} !== 9'h002) $display("FAIL abort_next_op got %h exp 002", {rc, rs}); else pass_cnt++;
    endtask

    task automatic test_ignore_start;
        int lat, bn; bit mv; logic [W-1:0] rs; logic rc; logic [W:0] exp_v;
        exp_v = model(8'h12, 8'h34, 1'b1, 1'b0);
        do_op(8'h12, 8'h34, 1'b1, 1'b0, 1'b1, lat, bn, mv, rs, rc);
        total_cnt++; if (lat !== W) $display("FAIL ign_latency got %0d exp %0d", lat, W); else pass_cnt++;
        total_cnt++; if ({rc, rs} !== exp_v) $display("FAIL ign_result got %h exp %h", {rc, rs}, exp_v); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_in = W'($urandom); b_in = W'($urandom);
            total_cnt++; if ({cout, sum} !== exp_v) $display("FAIL ign_hold_%0d got %h exp %h", i, {cout, sum}, exp_v); else pass_cnt++;
        end
        total_cnt++; if (busy !== 1'b0) $display("FAIL ign_idle_busy got %b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_random;
        int lat, bn; bit mv; logic [W-1:0] rs, ra, rb; logic rc, rcin; logic [W:0] exp_v;
        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom); rb = W'($urandom); rcin = 1'($urandom);
            if (i == 0) begin ra = '1; rb = '1; rcin = 1'b1; end
            exp_v = model(ra, rb, rcin, 1'b0);
            do_op(ra, rb, rcin, 1'b0, 1'b0, lat, bn, mv, rs, rc);
            total_cnt++; if (lat !== W) $display("FAIL rnd_latency_%0d got %0d exp %0d", i, lat, W); else pass_cnt++;
            total_cnt++; if ({rc, rs} !== exp_v) $display("FAIL rnd_%0d %h+%h+%b got %h exp %h", i, ra, rb, rcin, {rc, rs}, exp_v); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] ca, cb; logic cc; logic [W:0] exp_v;
        int last, cyc, seen;
        last = -1; cyc = 0; seen = 0;
        ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom);
        @(negedge clk);
        start = 1'b1; a_in = ca; b_in = cb; cin = cc; sub = 1'b0;
        while (seen < 4 && cyc < 20 * W) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                exp_v = model(ca, cb, cc, 1'b0);
                total_cnt++; if ({cout, sum} !== exp_v) $display("FAIL b2b_result_%0d got %h exp %h", seen, {cout, sum}, exp_v); else pass_cnt++;
                if (last >= 0) begin
                    total_cnt++; if (cyc - last !== W + 2) $display("FAIL b2b_period_%0d got %0d exp %0d", seen, cyc - last, W + 2); else pass_cnt++;
                end
                last = cyc; seen++;
                ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom);
                a_in = ca; b_in = cb; cin = cc;
            end
        end
        start = 1'b0;
        total_cnt++; if (seen !== 4) $display("FAIL b2b_done_count got %0d exp 4", seen); else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        int lat, bn; bit mv; logic [W-1:0] rs, ra, rb; logic rc, rs_sel, rcin; logic [W:0] exp_v;
        do_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, lat, bn, mv, rs, rc);
        total_cnt++; if ({rc, rs} !== 9'h10F) $display("FAIL sub_10_01 got %h exp 10f", {rc, rs}); else pass_cnt++;
        do_op(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, lat, bn, mv, rs, rc);
        total_cnt++; if ({rc, rs} !== 9'h0FF) $display("FAIL sub_01_02 got %h exp 0ff", {rc, rs}); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom); rb = W'($urandom); rcin = 1'($urandom); rs_sel = 1'($urandom);
            exp_v = model(ra, rb, rcin, rs_sel);
            do_op(ra, rb, rcin, rs_sel, 1'b0, lat, bn, mv, rs, rc);
            total_cnt++; if ({rc, rs} !== exp_v) $display("FAIL sub_rnd_%0d s=%b got %h exp %h", i, rs_sel, {rc, rs}, exp_v); else pass_cnt++;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_directed;
        test_abort;
        test_ignore_start;
        test_random;
        test_back_to_back;
`ifdef SERIAL_ADDER_SUB_EN
        test_sub;
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
